// File: rtl/vga_pkg.sv
// Shared timing constants, coordinate type and sync/visible-area decode
// for the 640x480@60 Hz raster generator.
package vga_pkg;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 2 ** COORD_W;

    // Default 640x480@60 Hz timing, in pixels and lines
    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_H_TOTAL = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int VGA_HS_INI  = VGA_H_VIS + VGA_H_FP;
    localparam int VGA_HS_FIM  = VGA_HS_INI + VGA_H_SYNC - 1;
    localparam int VGA_VS_INI  = VGA_V_VIS + VGA_V_FP;
    localparam int VGA_VS_FIM  = VGA_VS_INI + VGA_V_SYNC - 1;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } sinais_t;

    // Sync pulses are active-low inside their inclusive [ini, fim] window.
    function automatic sinais_t decodifica(
        input coord_t px,
        input coord_t py,
        input coord_t h_vis,
        input coord_t v_vis,
        input coord_t hs_ini,
        input coord_t hs_fim,
        input coord_t vs_ini,
        input coord_t vs_fim
    );
        sinais_t s;
        s.hsync    = !((px >= hs_ini) && (px <= hs_fim));
        s.vsync    = !((py >= vs_ini) && (py <= vs_fim));
        s.video_on = (px < h_vis) && (py < v_vis);
        return s;
    endfunction

endpackage

// File: rtl/contador_mod.sv
// Modulo-N counter with enable; exposes its next value so downstream
// registers can be decoded in step with the count itself.
module contador_mod
    import vga_pkg::*;
#(
    parameter int N = VGA_H_TOTAL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] valor,
    output logic [COORD_W-1:0] valor_prox,
    output logic               wrap
);

    localparam coord_t ULTIMO = coord_t'(N - 1);

    assign wrap = (valor == ULTIMO);

    always_comb begin
        // NOTE: default assignment first so every path drives valor_prox and no latch is inferred.
        valor_prox = valor;
        if (en) begin
            valor_prox = wrap ? '0 : valor + coord_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            valor <= '0;
        end else begin
            valor <= valor_prox;
        end
    end

endmodule

// File: rtl/gerador_varredura_vga.sv
// Raster scan generator: pixel-rate divider, horizontal/vertical counters and
// registered sync, visible-area and end-of-frame outputs.
module gerador_varredura_vga
    import vga_pkg::*;
#(
    parameter int DIV    = 2,
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               pixel_tick,
    output logic               fim_quadro
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam coord_t H_VIS_C = coord_t'(H_VIS);
    localparam coord_t V_VIS_C = coord_t'(V_VIS);
    localparam coord_t HS_INI  = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_FIM  = coord_t'(H_VIS + H_FP + H_SYNC - 1);
    localparam coord_t VS_INI  = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_FIM  = coord_t'(V_VIS + V_FP + V_SYNC - 1);

    localparam logic [3:0] DIV_ULT = 4'(DIV - 1);

    if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_invalido
        $error("gerador_varredura_vga: line or frame total exceeds 1024");
    end
    if (DIV < 1 || DIV > 16) begin : g_div_invalido
        $error("gerador_varredura_vga: DIV must be within 1..16");
    end

    logic [3:0] div_cnt;
    logic       h_wrap;
    logic       v_wrap;
    coord_t     x_prox;
    coord_t     y_prox;
    sinais_t    sinais_q;

    // The tick is registered from the divider state, so the first one lands
    // DIV clks after reset release and the counters step one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            pixel_tick <= 1'b0;
        end else begin
            pixel_tick <= (div_cnt == DIV_ULT);
            div_cnt    <= (div_cnt == DIV_ULT) ? '0 : div_cnt + 4'd1;
        end
    end

    contador_mod #(
        .N (H_TOTAL)
    ) u_cont_h (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (pixel_tick),
        .valor      (x),
        .valor_prox (x_prox),
        .wrap       (h_wrap)
    );

    contador_mod #(
        .N (V_TOTAL)
    ) u_cont_v (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (pixel_tick && h_wrap),
        .valor      (y),
        .valor_prox (y_prox),
        .wrap       (v_wrap)
    );

    // Decoding the next-state coordinates keeps the registered flags aligned with x/y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinais_q   <= '{hsync: 1'b1, vsync: 1'b1, video_on: 1'b1};
            fim_quadro <= 1'b0;
        end else begin
            sinais_q   <= decodifica(x_prox, y_prox, H_VIS_C, V_VIS_C,
                                     HS_INI, HS_FIM, VS_INI, VS_FIM);
            fim_quadro <= pixel_tick && h_wrap && v_wrap;
        end
    end

    assign hsync    = sinais_q.hsync;
    assign vsync    = sinais_q.vsync;
    assign video_on = sinais_q.video_on;

endmodule

// File: tb/tb_gerador_varredura_vga.sv
// Self-checking bench: three scan generators (default, tiny DIV=1, medium DIV=3)
// compared every clk against an arithmetic model of the raster timing.
module tb_gerador_varredura_vga;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       pixel_tick;
        logic       fim_quadro;
    } saida_t;

    typedef struct {
        int div;
        int hv;
        int hfp;
        int hs;
        int hbp;
        int vv;
        int vfp;
        int vs;
        int vbp;
    } cfg_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   n;

    cfg_t c_pad;
    cfg_t c_peq;
    cfg_t c_med;

    logic [9:0] a_x, a_y, b_x, b_y, m_x, m_y;
    logic a_hs, a_vs, a_von, a_tick, a_fim;
    logic b_hs, b_vs, b_von, b_tick, b_fim;
    logic m_hs, m_vs, m_von, m_tick, m_fim;

    gerador_varredura_vga u_pad (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (a_x),
        .y          (a_y),
        .hsync      (a_hs),
        .vsync      (a_vs),
        .video_on   (a_von),
        .pixel_tick (a_tick),
        .fim_quadro (a_fim)
    );

    gerador_varredura_vga #(
        .DIV (1), .H_VIS (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_VIS (2), .V_FP (1), .V_SYNC (1), .V_BP (1)
    ) u_peq (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (b_x),
        .y          (b_y),
        .hsync      (b_hs),
        .vsync      (b_vs),
        .video_on   (b_von),
        .pixel_tick (b_tick),
        .fim_quadro (b_fim)
    );

    gerador_varredura_vga #(
        .DIV (3), .H_VIS (20), .H_FP (3), .H_SYNC (5), .H_BP (4),
        .V_VIS (12), .V_FP (2), .V_SYNC (3), .V_BP (2)
    ) u_med (
        .clk        (clk),
        .rst_n      (rst_n),
        .x          (m_x),
        .y          (m_y),
        .hsync      (m_hs),
        .vsync      (m_vs),
        .video_on   (m_von),
        .pixel_tick (m_tick),
        .fim_quadro (m_fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs k rising edges after reset release (k=0: in reset).
    // Pixel advances happen on edges 1+DIV, 1+2*DIV, ...; the scan position is
    // simply the number of advances taken modulo the line and frame lengths.
    function automatic saida_t modelo(input cfg_t c, input int k);
        saida_t s;
        int ht;
        int vt;
        int p;
        int xx;
        int yy;
        ht = c.hv + c.hfp + c.hs + c.hbp;
        vt = c.vv + c.vfp + c.vs + c.vbp;
        p  = (k == 0) ? 0 : (k - 1) / c.div;
        xx = p % ht;
        yy = (p / ht) % vt;
        s.x          = 10'(xx);
        s.y          = 10'(yy);
        s.hsync      = !(xx >= c.hv + c.hfp && xx < c.hv + c.hfp + c.hs);
        s.vsync      = !(yy >= c.vv + c.vfp && yy < c.vv + c.vfp + c.vs);
        s.video_on   = (xx < c.hv) && (yy < c.vv);
        s.pixel_tick = (k > 0) && (k % c.div == 0);
        s.fim_quadro = (k >= 2) && ((k - 1) % c.div == 0) && (p % (ht * vt) == 0);
        return s;
    endfunction

    task automatic compara(input string tag, input saida_t o, input saida_t e);
        check({tag, ".x"},          32'(o.x),          32'(e.x));
        check({tag, ".y"},          32'(o.y),          32'(e.y));
        check({tag, ".hsync"},      32'(o.hsync),      32'(e.hsync));
        check({tag, ".vsync"},      32'(o.vsync),      32'(e.vsync));
        check({tag, ".video_on"},   32'(o.video_on),   32'(e.video_on));
        check({tag, ".pixel_tick"}, 32'(o.pixel_tick), 32'(e.pixel_tick));
        check({tag, ".fim_quadro"}, 32'(o.fim_quadro), 32'(e.fim_quadro));
    endtask

    task automatic confere_todos(input string tag);
        compara({tag, "/pad"}, {a_x, a_y, a_hs, a_vs, a_von, a_tick, a_fim}, modelo(c_pad, n));
        compara({tag, "/peq"}, {b_x, b_y, b_hs, b_vs, b_von, b_tick, b_fim}, modelo(c_peq, n));
        compara({tag, "/med"}, {m_x, m_y, m_hs, m_vs, m_von, m_tick, m_fim}, modelo(c_med, n));
    endtask

    task automatic passo();
        @(posedge clk);
        n++;
        #1;
    endtask

    initial begin
        int   alvo_y;
        bit   atingiu;
        int   hs_clks;
        int   intervalo;
        int   ult_peq;
        int   ult_med;
        int   pulsos_med;

        total      = 0;
        bad        = 0;
        n          = 0;
        hs_clks    = 0;
        intervalo  = 0;
        ult_peq    = -1;
        ult_med    = -1;
        pulsos_med = 0;
        atingiu    = 1'b0;
        c_pad = '{2, 640, 16, 96, 48, 480, 10, 2, 33};
        c_peq = '{1, 4, 1, 2, 1, 2, 1, 1, 1};
        c_med = '{3, 20, 3, 5, 4, 12, 2, 3, 2};

        // Held in reset for a random number of edges
        rst_n = 1'b0;
        repeat ($urandom_range(2, 5)) @(posedge clk);
        #1;
        confere_todos("reset");

        // Release between edges; edge count restarts from the release
        @(negedge clk);
        #($urandom_range(0, 3));
        rst_n = 1'b1;
        n     = 0;

        alvo_y = $urandom_range(1, 2);
        for (int c = 0; c < 12000 && !atingiu; c++) begin
            passo();
            confere_todos("varredura");
            if (a_y == 10'd0) begin
                if (!a_hs) hs_clks++;
                if (a_tick && a_von && a_x >= 10'd100 && a_x < 10'd200) intervalo++;
            end
            if (b_fim) begin
                if (ult_peq >= 0) check("periodo_quadro_peq", 32'(n - ult_peq), 32'd40);
                ult_peq = n;
            end
            if (m_fim) begin
                if (ult_med >= 0) check("periodo_quadro_med", 32'(n - ult_med), 32'(32 * 19 * 3));
                ult_med = n;
                pulsos_med++;
            end
            if (a_x == 10'd700 && a_y == 10'(alvo_y)) atingiu = 1'b1;
        end
        check("alvo_alcancado", 32'(atingiu), 32'd1);
        check("hsync_clks_linha0", 32'(hs_clks), 32'd192);
        check("intervalo_100_200", 32'(intervalo), 32'd100);
        check("pulsos_quadro_med", 32'(pulsos_med >= 2), 32'd1);

        // Asynchronous reset between edges at x=700 on the default generator
        #($urandom_range(1, 5));
        rst_n = 1'b0;
        #1;
        n = 0;
        confere_todos("reset_assincrono");
        repeat (2) @(posedge clk);
        #1;
        confere_todos("reset_mantido");

        @(negedge clk);
        rst_n = 1'b1;
        n     = 0;
        repeat ($urandom_range(1500, 2500)) begin
            passo();
            confere_todos("reinicio");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
